// File: rtl/spi_word_sequencer.sv
// -----------------------------------------------------------------------------
// spi_word_sequencer
//
// Sequences a multi-byte SPI transaction over a byte-wide, single-chip-select
// SPI master. A trigger (i_Start or a periodic auto-tick) starts a
// transaction. The sequencer sends N bytes of i_TX_Word, MSB-first, collects
// the N reply bytes into a right-aligned word and strobes it out. A reply
// byte that does not arrive in time aborts the transaction.
//
// Ports
//   i_Clk, i_Rst_L          clock (rising edge), async active-low reset
//   i_Start                 single-cycle transaction request
//   i_Auto_En               enables the periodic internal trigger
//   i_Byte_Count[2:0]       bytes per transaction (clamped to 1..4), sampled at start
//   i_TX_Word[31:0]         right-aligned command word, sampled at start
//   i_Clr_Flags             clears the sticky o_Overrun / o_Timeout flags
//   o_Busy                  transaction in progress
//   o_RX_Word[31:0]         assembled reply word, held between strobes
//   o_RX_Word_DV            one-cycle strobe marking o_RX_Word valid
//   o_Overrun, o_Timeout    sticky status flags
//   o_TX_Count[2:0]         byte count presented to the SPI master
//   o_TX_Byte[7:0], o_TX_DV byte to transmit and its one-cycle strobe
//   i_TX_Ready              SPI master can accept a byte
//   i_RX_DV, i_RX_Byte[7:0] received byte strobe and data
// -----------------------------------------------------------------------------
module spi_word_sequencer #(
  parameter int SAMPLE_PERIOD_CLKS = 16000,
  parameter int RX_TIMEOUT_CLKS    = 1024
) (
  input  logic        i_Clk,
  input  logic        i_Rst_L,
  input  logic        i_Start,
  input  logic        i_Auto_En,
  input  logic [2:0]  i_Byte_Count,
  input  logic [31:0] i_TX_Word,
  input  logic        i_Clr_Flags,
  output logic        o_Busy,
  output logic [31:0] o_RX_Word,
  output logic        o_RX_Word_DV,
  output logic        o_Overrun,
  output logic        o_Timeout,
  output logic [2:0]  o_TX_Count,
  output logic [7:0]  o_TX_Byte,
  output logic        o_TX_DV,
  input  logic        i_TX_Ready,
  input  logic        i_RX_DV,
  input  logic [7:0]  i_RX_Byte
);

  localparam logic [23:0] PERIOD_LAST  = 24'(SAMPLE_PERIOD_CLKS - 1);
  localparam logic [15:0] TIMEOUT_LAST = 16'(RX_TIMEOUT_CLKS - 1);

  typedef enum logic [1:0] {IDLE, SEND, WAIT_RX, DONE} state_t;

  state_t      state, state_next;
  logic [23:0] period_cnt;
  logic [15:0] byte_timer;
  logic        pending;
  logic        done_wait;   // first of the two DONE cycles
  logic [2:0]  byte_idx;    // bytes already exchanged
  logic [2:0]  byte_idx_inc;
  logic [31:0] tx_shift;    // command bytes, next byte to send in [31:24]
  logic [31:0] rx_acc;
  logic [2:0]  n_clamp;
  logic [31:0] tx_shift_init;

  logic auto_tick, trigger, overrun_set;
  logic load, send, accept, abort, finish;

  // The auto-tick fires on the cycle the counter wraps back to 0.
  assign auto_tick    = i_Auto_En && (period_cnt == PERIOD_LAST);
  assign trigger      = i_Start || auto_tick;
  assign o_Busy       = (state != IDLE);
  assign overrun_set  = trigger && (pending || o_Busy);
  assign byte_idx_inc = byte_idx + 3'd1;

  // Clamp the requested byte count to 1..4 and left-align the command so the
  // first byte to go out (byte N-1) sits in the top byte of the shifter.
  always_comb begin
    if (i_Byte_Count == 3'd0)     n_clamp = 3'd1;
    else if (i_Byte_Count > 3'd4) n_clamp = 3'd4;
    else                          n_clamp = i_Byte_Count;
    tx_shift_init = i_TX_Word << {3'd4 - n_clamp, 3'b000};
  end

  // NOTE: every output of a combinational block gets a default first so no
  // path leaves it unassigned; otherwise synthesis infers a latch.
  always_comb begin
    state_next = state;
    load       = 1'b0;
    send       = 1'b0;
    accept     = 1'b0;
    abort      = 1'b0;
    finish     = 1'b0;
    case (state)
      IDLE: begin
        if (pending && i_TX_Ready) begin
          load       = 1'b1;
          state_next = SEND;
        end
      end
      SEND: begin
        if (i_TX_Ready) begin
          send       = 1'b1;
          state_next = WAIT_RX;
        end
      end
      WAIT_RX: begin
        // A byte arriving on the last allowed cycle still counts.
        if (i_RX_DV) begin
          accept     = 1'b1;
          state_next = (byte_idx_inc == o_TX_Count) ? DONE : SEND;
        end else if (byte_timer == TIMEOUT_LAST) begin
          abort      = 1'b1;
          state_next = IDLE;
        end
      end
      DONE: begin
        // Two cycles in DONE place the word strobe two clocks after the
        // final reply byte was sampled.
        if (done_wait) begin
          finish     = 1'b1;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) state <= IDLE;
    else          state <= state_next;
  end

  // NOTE: the datapath registers are few and drive outputs, so all of them
  // are reset; this keeps the outputs defined immediately after reset.
  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      period_cnt   <= '0;
      byte_timer   <= '0;
      pending      <= 1'b0;
      done_wait    <= 1'b0;
      byte_idx     <= '0;
      tx_shift     <= '0;
      rx_acc       <= '0;
      o_TX_Count   <= 3'd1;
      o_TX_Byte    <= '0;
      o_TX_DV      <= 1'b0;
      o_RX_Word    <= '0;
      o_RX_Word_DV <= 1'b0;
      o_Overrun    <= 1'b0;
      o_Timeout    <= 1'b0;
    end else begin
      if (!i_Auto_En || auto_tick) period_cnt <= '0;
      else                         period_cnt <= period_cnt + 24'd1;

      if (load)                    pending <= 1'b0;
      else if (trigger && !o_Busy) pending <= 1'b1;

      if (load) begin
        o_TX_Count <= n_clamp;
        tx_shift   <= tx_shift_init;
        rx_acc     <= '0;
        byte_idx   <= '0;
      end

      o_TX_DV <= send;
      if (send) begin
        o_TX_Byte  <= tx_shift[31:24];
        tx_shift   <= {tx_shift[23:0], 8'h00};
        byte_timer <= '0;
      end

      if (accept) begin
        rx_acc   <= {rx_acc[23:0], i_RX_Byte};
        byte_idx <= byte_idx_inc;
      end else if (state == WAIT_RX) begin
        byte_timer <= byte_timer + 16'd1;
      end

      done_wait <= (state == DONE) && !done_wait;

      o_RX_Word_DV <= finish;
      if (finish) o_RX_Word <= rx_acc;

      // A flag raised in the same cycle as a clear request stays set.
      if (overrun_set)      o_Overrun <= 1'b1;
      else if (i_Clr_Flags) o_Overrun <= 1'b0;

      if (abort)            o_Timeout <= 1'b1;
      else if (i_Clr_Flags) o_Timeout <= 1'b0;
    end
  end

endmodule

// File: tb/tb_spi_word_sequencer.sv
// -----------------------------------------------------------------------------
// tb_spi_word_sequencer
//
// Self-checking bench for spi_word_sequencer. The bench plays the SPI master:
// it answers each transmitted byte with a reply byte after a random delay.
// Expected bytes and words come from a transaction-level model: the clamped
// byte count, the command word split MSB-first, and the reply bytes joined
// back into a right-aligned word.
// -----------------------------------------------------------------------------
module tb_spi_word_sequencer;

  logic        i_Clk = 1'b0;
  logic        i_Rst_L = 1'b0;
  logic        i_Start = 1'b0;
  logic        i_Auto_En = 1'b0;
  logic [2:0]  i_Byte_Count = 3'd1;
  logic [31:0] i_TX_Word = '0;
  logic        i_Clr_Flags = 1'b0;
  logic        o_Busy;
  logic [31:0] o_RX_Word;
  logic        o_RX_Word_DV;
  logic        o_Overrun;
  logic        o_Timeout;
  logic [2:0]  o_TX_Count;
  logic [7:0]  o_TX_Byte;
  logic        o_TX_DV;
  logic        i_TX_Ready = 1'b1;
  logic        i_RX_DV = 1'b0;
  logic [7:0]  i_RX_Byte = '0;

  spi_word_sequencer #(
    .SAMPLE_PERIOD_CLKS(8),
    .RX_TIMEOUT_CLKS   (4)
  ) dut (
    .i_Clk       (i_Clk),
    .i_Rst_L     (i_Rst_L),
    .i_Start     (i_Start),
    .i_Auto_En   (i_Auto_En),
    .i_Byte_Count(i_Byte_Count),
    .i_TX_Word   (i_TX_Word),
    .i_Clr_Flags (i_Clr_Flags),
    .o_Busy      (o_Busy),
    .o_RX_Word   (o_RX_Word),
    .o_RX_Word_DV(o_RX_Word_DV),
    .o_Overrun   (o_Overrun),
    .o_Timeout   (o_Timeout),
    .o_TX_Count  (o_TX_Count),
    .o_TX_Byte   (o_TX_Byte),
    .o_TX_DV     (o_TX_DV),
    .i_TX_Ready  (i_TX_Ready),
    .i_RX_DV     (i_RX_DV),
    .i_RX_Byte   (i_RX_Byte)
  );

  always #5 i_Clk = ~i_Clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Event counters sampled on the rising edge, read by the stimulus at the
  // falling edge.
  int cyc        = 0;
  int tx_dv_seen = 0;
  int rx_dv_out  = 0;
  always @(posedge i_Clk) begin
    cyc++;
    if (o_TX_DV === 1'b1)      tx_dv_seen++;
    if (o_RX_Word_DV === 1'b1) rx_dv_out++;
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish, got %0d cycles required fewer", cyc);
    $fatal(1);
  end

  // ---------------- transaction-level reference model ----------------
  logic [31:0] last_rx = '0;

  function automatic int clamp_n(input int bc);
    return (bc == 0) ? 1 : ((bc > 4) ? 4 : bc);
  endfunction

  // Byte k (0 = first on the wire) of an n-byte right-aligned word.
  function automatic logic [7:0] word_byte(input logic [31:0] w, input int n, input int k);
    return 8'(w >> (8 * (n - 1 - k)));
  endfunction

  function automatic logic [31:0] low_bytes(input logic [31:0] w, input int n);
    logic [63:0] mask;
    mask = (64'd1 << (8 * n)) - 64'd1;
    return 32'({32'd0, w} & mask);
  endfunction

  // ---------------- stimulus helpers ----------------
  task automatic check_reset_outputs(input string pfx);
    check({pfx, "_busy"},     o_Busy,       0);
    check({pfx, "_rx_word"},  o_RX_Word,    0);
    check({pfx, "_rx_dv"},    o_RX_Word_DV, 0);
    check({pfx, "_tx_dv"},    o_TX_DV,      0);
    check({pfx, "_overrun"},  o_Overrun,    0);
    check({pfx, "_timeout"},  o_Timeout,    0);
    check({pfx, "_tx_byte"},  o_TX_Byte,    0);
    check({pfx, "_tx_count"}, o_TX_Count,   1);
  endtask

  // Drive a one-cycle start; returns at the falling edge after it was sampled.
  task automatic start_txn(input logic [2:0] bc, input logic [31:0] w);
    i_Byte_Count = bc;
    i_TX_Word    = w;
    i_Start      = 1'b1;
    @(negedge i_Clk);
    i_Start = 1'b0;
  endtask

  task automatic wait_tx(output int lat, output bit ok);
    ok  = 1'b0;
    lat = 0;
    for (int i = 0; i < 24 && !ok; i++) begin
      @(negedge i_Clk);
      lat++;
      if (o_TX_DV === 1'b1) ok = 1'b1;
    end
    if (!ok) check("tx_dv_wait", o_TX_DV, 1);
  endtask

  // Reply with one byte after 'delay' cycles; returns at the falling edge
  // right after the reply was sampled.
  task automatic rx_byte(input logic [7:0] b, input int delay);
    repeat (delay) @(negedge i_Clk);
    i_RX_DV   = 1'b1;
    i_RX_Byte = b;
    @(negedge i_Clk);
    i_RX_DV   = 1'b0;
    i_RX_Byte = 8'($urandom);
    check("tx_dv_width", o_TX_DV, 0);
  endtask

  // Called right after the final reply was sampled: the word strobe must
  // appear exactly two clocks after that edge, for one cycle.
  task automatic expect_done(input logic [31:0] exp);
    int dv0;
    dv0 = rx_dv_out;
    check("dv_early1", o_RX_Word_DV, 0);
    @(negedge i_Clk);
    check("dv_early2", o_RX_Word_DV, 0);
    @(negedge i_Clk);
    check("dv_pulse", o_RX_Word_DV, 1);
    check("rx_word", o_RX_Word, exp);
    check("busy_after", o_Busy, 0);
    @(negedge i_Clk);
    check("dv_width", o_RX_Word_DV, 0);
    check("dv_count", 32'(rx_dv_out - dv0), 1);
    last_rx = exp;
  endtask

  task automatic run_txn(input logic [2:0] bc, input logic [31:0] w,
                         input logic [31:0] rx_src, input int max_delay);
    int n, lat;
    bit ok;
    n = clamp_n(int'(bc));
    check("rx_hold", o_RX_Word, last_rx);
    start_txn(bc, w);
    for (int k = 0; k < n; k++) begin
      wait_tx(lat, ok);
      if (!ok) return;
      if (k == 0) begin
        check("first_tx_lat", 32'(lat <= 2), 1);
        // Inputs are sampled at start only; disturbing them now must not matter.
        i_Byte_Count = 3'($urandom);
        i_TX_Word    = $urandom;
      end
      check("tx_byte",  o_TX_Byte,  word_byte(w, n, k));
      check("tx_count", o_TX_Count, n);
      check("busy",     o_Busy,     1);
      rx_byte(word_byte(rx_src, n, k), $urandom_range(max_delay, 0));
    end
    expect_done(low_bytes(rx_src, n));
  endtask

  // ---------------- test sequence ----------------
  initial begin
    int lat, dv0, tx0;
    bit ok;
    int t[4];
    logic [7:0] b;

    repeat (2) @(negedge i_Clk);
    check_reset_outputs("por");
    i_Rst_L = 1'b1;
    repeat (2) @(negedge i_Clk);
    check("idle_busy", o_Busy, 0);

    // Two-byte exchange with known data.
    run_txn(3'd2, 32'h0000A55A, 32'h00001234, 2);
    // Count clamping: 0 -> 1 byte, 7 -> 4 bytes.
    run_txn(3'd0, 32'h11223344, 32'h000000DE, 1);
    run_txn(3'd7, 32'h11223344, 32'hDEADBEEF, 1);

    // Random transactions.
    for (int i = 0; i < 16; i++)
      run_txn(3'($urandom), $urandom, $urandom, 2);

    // Periodic trigger: one transaction every 8 clocks, no overrun.
    i_Byte_Count = 3'd1;
    i_Auto_En    = 1'b1;
    for (int i = 0; i < 4; i++) begin
      wait_tx(lat, ok);
      if (!ok) break;
      t[i] = cyc;
      check("auto_tx_count", o_TX_Count, 1);
      b = 8'($urandom);
      rx_byte(b, $urandom_range(1, 0));
      expect_done({24'd0, b});
    end
    i_Auto_En = 1'b0;
    for (int i = 1; i < 4; i++) check("auto_period", 32'(t[i] - t[i-1]), 8);
    check("auto_overrun", o_Overrun, 0);
    tx0 = tx_dv_seen;
    repeat (12) @(negedge i_Clk);
    check("auto_off_idle", 32'(tx_dv_seen - tx0), 0);

    // Trigger while busy: flagged and dropped, then cleared.
    start_txn(3'd1, 32'h0000003C);
    wait_tx(lat, ok);
    i_Start = 1'b1;
    @(negedge i_Clk);
    i_Start = 1'b0;
    check("overrun_set", o_Overrun, 1);
    rx_byte(8'h77, 0);
    expect_done(32'h00000077);
    tx0 = tx_dv_seen;
    repeat (8) @(negedge i_Clk);
    check("overrun_dropped", 32'(tx_dv_seen - tx0), 0);
    check("overrun_sticky", o_Overrun, 1);
    i_Clr_Flags = 1'b1;
    @(negedge i_Clk);
    i_Clr_Flags = 1'b0;
    check("overrun_clr", o_Overrun, 0);

    // Set and clear in the same cycle: set wins.
    start_txn(3'd1, 32'h000000C3);
    wait_tx(lat, ok);
    i_Start     = 1'b1;
    i_Clr_Flags = 1'b1;
    @(negedge i_Clk);
    i_Start     = 1'b0;
    i_Clr_Flags = 1'b0;
    check("overrun_set_wins", o_Overrun, 1);
    rx_byte(8'h5A, 0);
    expect_done(32'h0000005A);
    i_Clr_Flags = 1'b1;
    @(negedge i_Clk);
    i_Clr_Flags = 1'b0;
    check("overrun_clr2", o_Overrun, 0);

    // Reply timeout after 4 clocks in WAIT_RX.
    start_txn(3'd1, $urandom);
    wait_tx(lat, ok);
    dv0 = rx_dv_out;
    repeat (3) @(negedge i_Clk);
    check("timeout_early", o_Timeout, 0);
    check("timeout_busy", o_Busy, 1);
    @(negedge i_Clk);
    check("timeout_set", o_Timeout, 1);
    check("timeout_idle", o_Busy, 0);
    check("timeout_word", o_RX_Word, last_rx);
    // A reply arriving after the abort is ignored.
    i_RX_DV = 1'b1;
    @(negedge i_Clk);
    i_RX_DV = 1'b0;
    repeat (4) @(negedge i_Clk);
    check("timeout_no_dv", 32'(rx_dv_out - dv0), 0);
    check("timeout_late_busy", o_Busy, 0);
    i_Clr_Flags = 1'b1;
    @(negedge i_Clk);
    i_Clr_Flags = 1'b0;
    check("timeout_clr", o_Timeout, 0);

    // Reset in the middle of a transaction.
    start_txn(3'd2, $urandom);
    wait_tx(lat, ok);
    i_Start = 1'b1;
    @(negedge i_Clk);
    i_Start = 1'b0;
    check("pre_rst_overrun", o_Overrun, 1);
    dv0 = rx_dv_out;
    tx0 = tx_dv_seen;
    i_Rst_L = 1'b0;
    #1;
    check_reset_outputs("mid_rst");
    @(negedge i_Clk);
    i_Rst_L = 1'b1;
    @(negedge i_Clk);
    i_RX_DV   = 1'b1;
    i_RX_Byte = 8'hA5;
    @(negedge i_Clk);
    i_RX_DV = 1'b0;
    repeat (8) @(negedge i_Clk);
    check("rst_no_dv", 32'(rx_dv_out - dv0), 0);
    check("rst_no_tx", 32'(tx_dv_seen - tx0), 0);
    check("rst_busy", o_Busy, 0);
    check("rst_word", o_RX_Word, 0);
    last_rx = '0;

    // Normal operation resumes on a new trigger.
    run_txn(3'd3, $urandom, $urandom, 2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
